// File: rtl/ds1302_serial_io.sv
// DS1302 3-wire serial engine: one command byte plus one data byte per request.
// SIO is split into out/oe/in so the pad tri-state lives at the top level.
module ds1302_serial_io #(
  parameter int CLK_DIV     = 50,
  parameter int CE_SETUP    = 200,
  parameter int CE_INACTIVE = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] func_start,
  input  logic [7:0] register_addr,
  input  logic [7:0] write_data,
  output logic       func_done,
  output logic [7:0] read_data,
  output logic       busy,
  output logic       rtc_ce,
  output logic       rtc_sclk,
  output logic       rtc_sio_out,
  output logic       rtc_sio_oe,
  input  logic       rtc_sio_in
);

  localparam int SLOT = 2 * CLK_DIV;
  localparam int M1   = (CE_SETUP > SLOT) ? CE_SETUP : SLOT;
  localparam int MAXC = (M1 > CE_INACTIVE) ? M1 : CE_INACTIVE;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    slot;
  logic [3:0]    nxt;
  logic          armed;
  logic          rd_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    shreg;
  logic [1:0]    sio_sync;
  logic          req;

  assign nxt = slot + 4'd1;
  assign req = (func_start == 2'b10) || (func_start == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sio_sync <= 2'b00;
    else        sio_sync <= {sio_sync[0], rtc_sio_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      slot        <= '0;
      armed       <= 1'b1;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      shreg       <= '0;
      func_done   <= 1'b0;
      read_data   <= '0;
      busy        <= 1'b0;
      rtc_ce      <= 1'b0;
      rtc_sclk    <= 1'b0;
      rtc_sio_out <= 1'b0;
      rtc_sio_oe  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (func_start == 2'b00) armed <= 1'b1;
          if (armed && req) begin
            rd_q   <= (func_start == 2'b01);
            addr_q <= register_addr;
            data_q <= write_data;
            state  <= SETUP;
            cnt    <= '0;
            busy   <= 1'b1;
            rtc_ce <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(CE_SETUP - 1)) begin
            state       <= SHIFT;
            cnt         <= '0;
            slot        <= '0;
            rtc_sio_oe  <= 1'b1;
            rtc_sio_out <= addr_q[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            rtc_sclk <= 1'b1;
            cnt      <= cnt + 1'b1;
            // Sample at the end of the low half, after the device has settled.
            if (rd_q && slot[3]) shreg <= {sio_sync[1], shreg[7:1]};
          end else if (cnt == CW'(SLOT - 1)) begin
            rtc_sclk <= 1'b0;
            cnt      <= '0;
            if (slot == 4'd15) begin
              state       <= HOLD;
              rtc_sio_oe  <= 1'b0;
              rtc_sio_out <= 1'b0;
            end else begin
              slot <= nxt;
              if (rd_q && nxt[3]) begin
                rtc_sio_oe  <= 1'b0;
                rtc_sio_out <= 1'b0;
              end else begin
                rtc_sio_out <= nxt[3] ? data_q[nxt[2:0]]
                                      : addr_q[nxt[2:0]];
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            state  <= GAP;
            cnt    <= '0;
            rtc_ce <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(CE_INACTIVE - 1)) begin
            state     <= DONE;
            cnt       <= '0;
            func_done <= 1'b1;
            armed     <= 1'b0;
            if (rd_q) read_data <= shreg;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cnt       <= '0;
          func_done <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_serial_io.sv
// Scoreboard bench for ds1302_serial_io with a DS1302 read-side model.
// Expected SCLK-rise bits and read bytes are queued at request time.
module tb_ds1302_serial_io;

  localparam int LAT = 8 + 33 * 4 + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] func_start = 2'b00;
  logic [7:0] register_addr = 8'h00;
  logic [7:0] write_data = 8'h00;
  logic       func_done;
  logic [7:0] read_data;
  logic       busy;
  logic       rtc_ce;
  logic       rtc_sclk;
  logic       rtc_sio_out;
  logic       rtc_sio_oe;
  logic       rtc_sio_in = 1'b0;

  ds1302_serial_io #(
    .CLK_DIV(4), .CE_SETUP(8), .CE_INACTIVE(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .func_start(func_start),
    .register_addr(register_addr),
    .write_data(write_data),
    .func_done(func_done),
    .read_data(read_data),
    .busy(busy),
    .rtc_ce(rtc_ce),
    .rtc_sclk(rtc_sclk),
    .rtc_sio_out(rtc_sio_out),
    .rtc_sio_oe(rtc_sio_oe),
    .rtc_sio_in(rtc_sio_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic oe;
    logic b;
  } rise_t;

  rise_t      exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] rd_model = 8'h00;
  logic [7:0] dev_byte = 8'h00;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int rises = 0;
  int falls = 0;
  int n_xfer = 0;
  int n_done = 0;
  logic prev_ce = 1'b0;
  logic prev_sclk = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rise_t e;
    cyc++;
    if (rtc_ce && !prev_ce) begin
      t0 = cyc;
      rises = 0;
      falls = 0;
      n_xfer++;
    end
    if (rtc_sclk && !prev_sclk) begin
      rises++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rise", 32'(rises), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sio_oe", 32'(rtc_sio_oe), 32'(e.oe));
        if (e.oe) chk("sio_bit", 32'(rtc_sio_out), 32'(e.b));
      end
    end
    if (!rtc_sclk && prev_sclk && rises >= 8) begin
      rtc_sio_in = dev_byte[falls % 8];
      falls++;
    end
    if (func_done) begin
      n_done++;
      chk("latency", 32'(cyc - t0), 32'(LAT));
      if (rd_q.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
      else chk("read_data", 32'(read_data), 32'(rd_q.pop_front()));
    end
    prev_ce = rtc_ce;
    prev_sclk = rtc_sclk;
  end

  task automatic start(input logic rd, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] dev,
                       input logic keep);
    int k;
    @(negedge clk);
    dev_byte = dev;
    func_start = rd ? 2'b01 : 2'b10;
    register_addr = a;
    write_data = d;
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, a[i]});
    for (int i = 0; i < 8; i++)
      exp_q.push_back(rd ? '{1'b0, 1'b0} : '{1'b1, d[i]});
    if (rd) rd_model = dev;
    rd_q.push_back(rd_model);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 4);
    chk("busy_on_accept", 32'(busy), 32'(1));
    if (!keep) func_start = 2'b00;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!func_done && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (!func_done) chk("done_timeout", 32'(0), 32'(1));
    @(negedge clk);
  endtask

  task automatic wait_rises(input int n);
    int k;
    k = 0;
    while (rises < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (rises < n) chk("rise_timeout", 32'(rises), 32'(n));
  endtask

  initial begin
    int x0;
    int d0;
    logic busy_seen;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        32'({rtc_ce, rtc_sclk, rtc_sio_out, rtc_sio_oe,
             func_done, busy, read_data}), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));

    start(1'b0, 8'h8E, 8'h00, 8'h00, 1'b0);
    wait_done();
    chk("busy_after_wr", 32'(busy), 32'(0));

    start(1'b1, 8'h81, 8'h00, 8'h59, 1'b0);
    wait_done();

    start(1'b0, 8'h80, 8'h5A, 8'h00, 1'b0);
    wait_rises(3);
    register_addr = 8'hFF;
    write_data = 8'h00;
    wait_done();
    chk("wr_keeps_rd", 32'(read_data), 32'(8'h59));

    x0 = n_xfer;
    start(1'b0, 8'h90, 8'hC3, 8'h00, 1'b1);
    wait_done();
    func_start = 2'b00;
    repeat (30) @(negedge clk);
    chk("one_xfer", 32'(n_xfer - x0), 32'(1));
    start(1'b1, 8'h83, 8'h00, 8'hA5, 1'b0);
    wait_done();
    chk("second_req", 32'(n_xfer - x0), 32'(2));

    x0 = n_xfer;
    d0 = n_done;
    busy_seen = 1'b0;
    func_start = 2'b11;
    repeat (100) begin
      @(negedge clk);
      if (busy || rtc_ce) busy_seen = 1'b1;
    end
    func_start = 2'b00;
    chk("f11_busy_ce", 32'(busy_seen), 32'(0));
    chk("f11_xfer", 32'(n_xfer - x0), 32'(0));
    chk("f11_done", 32'(n_done - d0), 32'(0));

    start(1'b0, 8'h8E, 8'hFF, 8'h00, 1'b0);
    wait_rises(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs",
        32'({rtc_ce, rtc_sclk, rtc_sio_out, rtc_sio_oe,
             func_done, busy, read_data}), 32'(0));
    exp_q.delete();
    rd_q.delete();
    rd_model = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start(1'b1, 8'h85, 8'h00, 8'h3C, 1'b0);
    wait_done();
    chk("post_rst_rd", 32'(read_data), 32'(8'h3C));
    chk("queues_empty", 32'(exp_q.size() + rd_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
